// File: rtl/pixel_write_buffer.sv
// Pixel write buffer between the box plotter and the framebuffer port.
// Clips, queues and issues linear-address writes with lossy overflow.
module pixel_write_buffer #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120,
   parameter int DEPTH           = 8,
   parameter int ADDR_W          = 15
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [7:0]        iX,
   input  logic [6:0]        iY,
   input  logic [2:0]        iColour,
   input  logic              iPlot,
   input  logic              iWrReady,
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oAddr,
   output logic [2:0]        oData,
   output logic              oFull,
   output logic              oIdle,
   output logic [7:0]        oClipCount,
   output logic [7:0]        oDropCount
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + 3;

   logic [EW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_data;
   logic [7:0]        r_clip_cnt;
   logic [7:0]        r_drop_cnt;

   logic              w_oob;
   logic              w_clip;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [ADDR_W-1:0] w_addr;
   logic [EW-1:0]     w_head;

   assign w_oob  = (int'(iX) >= X_SCREEN_PIXELS) ||
                   (int'(iY) >= Y_SCREEN_PIXELS);
   assign w_clip = iPlot && w_oob;
   assign w_full = (r_count == CW'(DEPTH));
   // A full slot that is being consumed frees room for the head.
   assign w_pop  = (r_count != '0) && (!r_wr_en || iWrReady);
   // A pop frees one entry, so a push while full still lands.
   assign w_push = iPlot && !w_oob && (!w_full || w_pop);
   assign w_drop = iPlot && !w_oob && w_full && !w_pop;
   assign w_addr = ADDR_W'(iY) * ADDR_W'(X_SCREEN_PIXELS)
                 + ADDR_W'(iX);
   assign w_head = r_mem[r_rptr];

   // FIFO storage; contents are don't-care until a push.
   always_ff @(posedge clock) begin
      if (resetn && w_push)
         r_mem[r_wptr] <= {w_addr, iColour};
   end

   // Circular pointers and occupancy count.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // Output slot: refill from the head, hold while stalled.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (w_pop) begin
         r_wr_en <= 1'b1;
         r_addr  <= w_head[EW-1:3];
         r_data  <= w_head[2:0];
      end else if (iWrReady) begin
         r_wr_en <= 1'b0;
      end
   end

   // Saturating clip and drop diagnostics.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_clip_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_clip && r_clip_cnt != 8'hFF)
            r_clip_cnt <= r_clip_cnt + 8'd1;
         if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign oWrEn      = r_wr_en;
   assign oAddr      = r_addr;
   assign oData      = r_data;
   assign oFull      = w_full;
   assign oIdle      = (r_count == '0) && !r_wr_en;
   assign oClipCount = r_clip_cnt;
   assign oDropCount = r_drop_cnt;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer.
// Random and directed pixels against a queue-based reference model.
module tb_pixel_write_buffer;

   localparam int DEPTH = 8;
   localparam int XS    = 160;
   localparam int YS    = 120;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  iX = '0;
   logic [6:0]  iY = '0;
   logic [2:0]  iColour = '0;
   logic        iPlot = 1'b0;
   logic        iWrReady = 1'b0;
   logic        oWrEn;
   logic [14:0] oAddr;
   logic [2:0]  oData;
   logic        oFull;
   logic        oIdle;
   logic [7:0]  oClipCount;
   logic [7:0]  oDropCount;

   pixel_write_buffer #(
      .X_SCREEN_PIXELS(XS),
      .Y_SCREEN_PIXELS(YS),
      .DEPTH(DEPTH),
      .ADDR_W(15)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .iX(iX),
      .iY(iY),
      .iColour(iColour),
      .iPlot(iPlot),
      .iWrReady(iWrReady),
      .oWrEn(oWrEn),
      .oAddr(oAddr),
      .oData(oData),
      .oFull(oFull),
      .oIdle(oIdle),
      .oClipCount(oClipCount),
      .oDropCount(oDropCount)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference: pending pixels as {addr, colour} plus one output slot.
   int q_addr[$];
   int q_col[$];
   bit m_v;
   int m_addr;
   int m_col;
   int m_clip;
   int m_drop;
   int m_wr;
   int dut_wr;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(bit rst, bit plot, int x, int y,
                             int c, bit rdy);
      bit pop;
      if (rst) begin
         q_addr.delete();
         q_col.delete();
         m_v = 0; m_clip = 0; m_drop = 0;
         return;
      end
      pop = (q_addr.size() > 0) && (!m_v || rdy);
      if (m_v && rdy) m_wr++;
      if (pop) begin
         m_v = 1;
         m_addr = q_addr.pop_front();
         m_col = q_col.pop_front();
      end else if (rdy) begin
         m_v = 0;
      end
      if (plot) begin
         if (x >= XS || y >= YS) begin
            if (m_clip < 255) m_clip++;
         end else if (q_addr.size() < DEPTH) begin
            q_addr.push_back(y * XS + x);
            q_col.push_back(c);
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end
   endtask

   task automatic check_all();
      chk("wren", 32'(oWrEn), 32'(m_v));
      if (m_v) begin
         chk("addr", 32'(oAddr), m_addr);
         chk("data", 32'(oData), m_col);
      end
      chk("full", 32'(oFull), 32'(q_addr.size() == DEPTH));
      chk("idle", 32'(oIdle), 32'(q_addr.size() == 0 && !m_v));
      chk("clip", 32'(oClipCount), m_clip);
      chk("drop", 32'(oDropCount), m_drop);
   endtask

   task automatic step(bit plot, int x, int y, int c, bit rdy);
      iPlot = plot;
      iX = 8'(x);
      iY = 7'(y);
      iColour = 3'(c);
      iWrReady = rdy;
      #1;
      if (resetn && oWrEn && iWrReady) dut_wr++;
      @(posedge clock);
      model_edge(!resetn, plot, x, y, c, rdy);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(1, 10, 10, 3, 1);
      resetn = 1'b1;
      chk("rst_addr", 32'(oAddr), 0);
      chk("rst_data", 32'(oData), 0);
      chk("rst_idle", 32'(oIdle), 1);
   endtask

   task automatic rand_oob(output int x, output int y);
      if ($urandom_range(0, 1) == 1) begin
         x = $urandom_range(XS, 255);
         y = $urandom_range(0, 127);
      end else begin
         x = $urandom_range(0, 255);
         y = $urandom_range(YS, 127);
      end
   endtask

   initial begin
      int x;
      int y;
      int w0;
      int d0;
      m_wr = 0;
      dut_wr = 0;
      @(negedge clock);

      // Reset, then a single pixel.
      do_reset();
      step(1, 3, 2, 5, 1);
      chk("single_lat0", 32'(oWrEn), 0);
      step(0, 0, 0, 0, 1);
      chk("single_wren", 32'(oWrEn), 1);
      chk("single_addr", 32'(oAddr), 323);
      chk("single_data", 32'(oData), 5);
      step(0, 0, 0, 0, 1);
      chk("single_once", 32'(oWrEn), 0);
      chk("single_idle", 32'(oIdle), 1);

      // Stall hold on the last pixel.
      w0 = dut_wr;
      step(1, 159, 119, 7, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("stall_addr", 32'(oAddr), 19199);
      chk("stall_data", 32'(oData), 7);
      chk("stall_none", dut_wr - w0, 0);
      step(0, 0, 0, 0, 1);
      chk("stall_one", dut_wr - w0, 1);

      // Overflow burst of 16 with the port stalled.
      for (int i = 0; i < 16; i++) step(1, i, 1, i % 8, 0);
      chk("ovf_full", 32'(oFull), 1);
      chk("ovf_drop", 32'(oDropCount), 7);
      w0 = dut_wr;
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
      chk("ovf_writes", dut_wr - w0, 9);

      // Fill, then sustained push+pop while full.
      for (int i = 0; i < 9; i++) step(1, i + 20, 5, i % 8, 0);
      chk("pp_full0", 32'(oFull), 1);
      d0 = 32'(oDropCount);
      for (int i = 0; i < 20; i++)
         step(1, $urandom_range(0, XS - 1), $urandom_range(0, YS - 1),
              $urandom_range(0, 7), 1);
      chk("pp_full1", 32'(oFull), 1);
      chk("pp_drop", 32'(oDropCount), d0);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);

      // Clip and saturation.
      do_reset();
      w0 = dut_wr;
      step(1, 160, 0, 1, 1);
      step(1, 0, 120, 2, 1);
      step(1, 255, 127, 3, 1);
      step(0, 0, 0, 0, 1);
      chk("clip3", 32'(oClipCount), 3);
      chk("clip_nowr", dut_wr - w0, 0);
      for (int i = 0; i < 300; i++) begin
         rand_oob(x, y);
         step(1, x, y, $urandom_range(0, 7), $urandom_range(0, 1));
      end
      chk("clip_sat", 32'(oClipCount), 255);
      chk("clip_nodrop", 32'(oDropCount), 0);

      // Mid-operation reset with 5 queued plus the slot.
      do_reset();
      for (int i = 0; i < 6; i++) step(1, i, 3, i, 0);
      chk("mid_wren", 32'(oWrEn), 1);
      do_reset();
      chk("mid_wren0", 32'(oWrEn), 0);
      chk("mid_clip0", 32'(oClipCount), 0);
      w0 = dut_wr;
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
      chk("mid_stale", dut_wr - w0, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) rand_oob(x, y);
         else begin
            x = $urandom_range(0, XS - 1);
            y = $urandom_range(0, YS - 1);
         end
         step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7),
              $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
      chk("total_writes", dut_wr, m_wr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Downstream stage of the box/clear-screen plotter: accepts its per-cycle pixel stream (x, y, colour, plot strobe), buffers it, and issues linear-address writes to the 160x120x3 framebuffer write port.
- The framebuffer port may stall (ready/valid); the buffer absorbs plotter bursts (16-pixel box, 40-pixel clear) and clips or drops pixels it cannot store, with saturating diagnostic counters.

Parameters:
- X_SCREEN_PIXELS, 160, screen width; clip bound for x and address row stride.
- Y_SCREEN_PIXELS, 120, screen height; clip bound for y.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ADDR_W, 15, framebuffer address width; must hold X_SCREEN_PIXELS*Y_SCREEN_PIXELS-1.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- iX  in  8  pixel x coordinate.
- iY  in  7  pixel y coordinate.
- iColour  in  3  pixel colour.
- iPlot  in  1  pixel valid strobe; one pixel per cycle when high.
- iWrReady  in  1  framebuffer accepts write this cycle.
- oWrEn  out  1  write valid.
- oAddr  out  ADDR_W  linear address, y*X_SCREEN_PIXELS + x.
- oData  out  3  colour to write.
- oFull  out  1  FIFO holds DEPTH entries.
- oIdle  out  1  FIFO empty and output stage empty.
- oClipCount  out  8  saturating count of out-of-range pixels.
- oDropCount  out  8  saturating count of pixels lost to overflow.

Behaviour:
- Reset (resetn=0 at rising edge, any state): FIFO and output stage flushed. oWrEn=0, oAddr=0, oData=0, oFull=0, oIdle=1, both counters=0. Pixels presented in the reset cycle are discarded.
- Input sampling: iPlot=1 at edge k → pixel evaluated.
  - Clip: if iX >= X_SCREEN_PIXELS or iY >= Y_SCREEN_PIXELS, the pixel is not stored and oClipCount increments.
  - Otherwise it is pushed, subject to the overflow rule.
  - No input handshake. The upstream plotter cannot stall, so overflow is lossy.
- Address: computed at push time as (y<<7)+(y<<5)+x for the default width (generic y*X_SCREEN_PIXELS+x), zero-extended to ADDR_W. The FIFO stores {addr, colour}.
- Output stage: one register slot, {oWrEn, oAddr, oData}.
  - The slot loads the FIFO head at an edge when it is empty, or when it is full and iWrReady=1 (consumed that cycle).
  - While oWrEn=1 and iWrReady=0, oAddr and oData hold stable.
  - A write transfers at an edge where oWrEn=1 and iWrReady=1.
- Latency: with an empty buffer and iWrReady=1, a pixel pushed at edge k drives oWrEn=1 after edge k+1. Sustained throughput is 1 pixel/cycle. Total storage is DEPTH+1 pixels.
- FIFO: circular read/write pointers plus a count of 0..DEPTH.
  - Push and pop in the same cycle leaves the count unchanged, including at count=DEPTH: a push while full succeeds if a pop occurs that edge.
  - Push while full with no pop: pixel discarded, oDropCount increments, FIFO contents unchanged.
  - Pop while empty: no action.
  - Pointers wrap modulo DEPTH.
- oFull = (count==DEPTH), registered-consistent with count. oIdle = (count==0) && !oWrEn.
- Counters saturate at 255, never wrap. A clipped pixel never counts as dropped.
- Order is preserved: writes leave in acceptance order. There is no reordering or coalescing, so duplicate addresses are written twice.

Test Plan:
- Reset then single pixel: iX=3, iY=2, iColour=5, iPlot 1 cycle, iWrReady=1 → oWrEn=1 for exactly 1 cycle, 2 edges after the push edge, oAddr=323, oData=5; oIdle returns to 1.
- Stall hold: push x=159,y=119,c=7 with iWrReady=0 for 10 cycles → oWrEn=1, oAddr=19199, oData=7 stable throughout; one write completes on the first iWrReady=1 edge.
- Overflow: iWrReady=0, 16 consecutive valid pixels → 9 stored (DEPTH+1), oFull=1, oDropCount=7. Then iWrReady=1 → exactly 9 writes, in order, equal to the first 9 pixels.
- Full push+pop: fill to oFull=1, then iWrReady=1 with a continuous iPlot stream for 20 cycles → oDropCount unchanged, count stays DEPTH, no pixel lost.
- Clip and saturation: pixels (160,0), (0,120), (255,127) → no writes, oClipCount=3. Then 300 out-of-range pixels → oClipCount=255, oDropCount=0.
- Mid-operation reset: buffer holding 5 entries with oWrEn=1, resetn=0 for 1 edge → oWrEn=0, oIdle=1, counters 0 next cycle; no stale writes after reset release.
